// File: rtl/dht11_leitor.sv
// rtl/dht11_leitor.sv - DHT11 single-wire bus master: start pulse, 40-bit decode, checksum
// Line is driven only through the open-drain enable; all timing runs in system clock cycles.
module dht11_leitor #(
  parameter int CLOCK_HZ      = 50_000_000,
  parameter int START_LOW_US  = 18000,
  parameter int TIMEOUT_US    = 200,
  parameter int BIT_THRESH_US = 50
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir,
  input  logic        dht_data_in,
  output logic        dht_data_oe,
  output logic [15:0] umidade,
  output logic [15:0] temperatura,
  output logic        pronto,
  output logic        erro_checksum,
  output logic        erro_timeout,
  output logic        ocupado,
  output logic [3:0]  db_estado
);

  localparam int CYC_US    = CLOCK_HZ / 1_000_000;
  localparam int START_CYC = START_LOW_US * CYC_US;
  localparam int TMO_CYC   = TIMEOUT_US * CYC_US;
  localparam int THR_CYC   = BIT_THRESH_US * CYC_US;
  localparam int CNT_MAX   = (START_CYC > TMO_CYC) ? START_CYC : TMO_CYC;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TMO_CYC - 1);
  localparam logic [CNT_W-1:0] THR_M1     = CNT_W'(THR_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(CNT_MAX);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_START_LOW = 4'd1,
    S_RELEASE   = 4'd2,
    S_RESP_LOW  = 4'd3,
    S_RESP_HIGH = 4'd4,
    S_BIT_LOW   = 4'd5,
    S_BIT_HIGH  = 4'd6,
    S_CHECK     = 4'd7,
    S_DONE      = 4'd8,
    S_ERRO      = 4'd9
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync2_q, line_prev_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [39:0]       shift_q;
  logic [5:0]        bit_cnt_q;
  logic [15:0]       umid_q, temp_q;
  logic              erro_chk_q, erro_tmo_q;

  logic              line_s, rose, fell, timeout, bit_val, last_bit, chk_ok;
  logic [7:0]        sum8;

  assign line_s   = sync2_q;
  assign rose     = line_s & ~line_prev_q;
  assign fell     = ~line_s & line_prev_q;
  assign timeout  = (cnt_q == TMO_LAST);
  // cnt_q lags the true high width by one: the entry edge cycle is not counted
  assign bit_val  = (cnt_q >= THR_M1);
  assign last_bit = (bit_cnt_q == 6'd39);
  assign sum8     = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];
  assign chk_ok   = (sum8 == shift_q[7:0]);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (medir) state_d = S_START_LOW;
      S_START_LOW: if (cnt_q == START_LAST) state_d = S_RELEASE;
      S_RELEASE: begin
        if (fell)         state_d = S_RESP_LOW;
        else if (timeout) state_d = S_ERRO;
      end
      S_RESP_LOW: begin
        if (rose)         state_d = S_RESP_HIGH;
        else if (timeout) state_d = S_ERRO;
      end
      S_RESP_HIGH: begin
        if (fell)         state_d = S_BIT_LOW;
        else if (timeout) state_d = S_ERRO;
      end
      S_BIT_LOW: begin
        if (rose)         state_d = S_BIT_HIGH;
        else if (timeout) state_d = S_ERRO;
      end
      S_BIT_HIGH: begin
        if (fell)         state_d = last_bit ? S_CHECK : S_BIT_LOW;
        else if (timeout) state_d = S_ERRO;
      end
      S_CHECK:     state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      S_ERRO:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dht_data_oe = (state_q == S_START_LOW);
    pronto      = (state_q == S_DONE) || (state_q == S_ERRO);
    ocupado     = (state_q != S_IDLE);
    db_estado   = state_q;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      line_prev_q <= 1'b1;
      cnt_q       <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      umid_q      <= '0;
      temp_q      <= '0;
      erro_chk_q  <= 1'b0;
      erro_tmo_q  <= 1'b0;
    end else begin
      sync1_q     <= dht_data_in;
      sync2_q     <= sync1_q;
      line_prev_q <= sync2_q;
      cnt_q       <= cnt_d;
      if (state_q == S_IDLE && medir) begin
        shift_q    <= '0;
        bit_cnt_q  <= '0;
        erro_chk_q <= 1'b0;
        erro_tmo_q <= 1'b0;
      end
      if (state_q == S_BIT_HIGH && fell) begin
        shift_q   <= {shift_q[38:0], bit_val};
        bit_cnt_q <= (bit_cnt_q == 6'd40) ? 6'd40 : bit_cnt_q + 6'd1;
      end
      if (state_q == S_CHECK) begin
        if (chk_ok) begin
          umid_q <= shift_q[39:24];
          temp_q <= shift_q[23:8];
        end else begin
          erro_chk_q <= 1'b1;
        end
      end
      // Flag is raised on entry so it is already valid during the pronto cycle
      if (state_d == S_ERRO && state_q != S_ERRO) erro_tmo_q <= 1'b1;
    end
  end

  assign umidade       = umid_q;
  assign temperatura   = temp_q;
  assign erro_checksum = erro_chk_q;
  assign erro_timeout  = erro_tmo_q;

endmodule
